// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the multiply-accumulate / divide controller.
// Op codes, FSM states and datapath widths live here so every file agrees on them.
package muldiv_ctrl_pkg;

  localparam int WORD_W  = 32;
  localparam int DWORD_W = 64;

  // One restoring step per result bit
  localparam logic [5:0] DIV_STEPS = 6'd32;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MADD  = 3'd1,
    OP_MADDU = 3'd2,
    OP_MSUB  = 3'd3,
    OP_MSUBU = 3'd4,
    OP_DIV   = 3'd5,
    OP_DIVU  = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MAC,
    ST_DIV_ON,
    ST_DIV_ZERO,
    ST_DONE
  } state_e;

  function automatic logic is_muldiv_op(input logic [2:0] op);
    return (op != OP_NOP) && (op != OP_RSVD);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_div_core.sv
// Unsigned restoring divider: one shift-subtract step per i_step cycle, 32 steps total.
// Only instantiated when MULDIV_DIV_EN is defined.
module div_core
  import muldiv_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [WORD_W-1:0] i_dividend,
  input  logic [WORD_W-1:0] i_divisor,
  output logic [WORD_W-1:0] o_quot,
  output logic [WORD_W-1:0] o_rem,
  output logic              o_done
);

  logic [WORD_W-1:0] r_quot;
  logic [WORD_W-1:0] r_rem;
  logic [WORD_W-1:0] r_divisor;
  logic [5:0]        r_cnt;

  logic [WORD_W:0] w_shift;
  logic [WORD_W:0] w_diff;

  // Remainder stays below the divisor, so the shifted value fits in WORD_W+1 bits
  assign w_shift = {r_rem, r_quot[WORD_W-1]};
  assign w_diff  = w_shift - {1'b0, r_divisor};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_quot    <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
      r_cnt     <= '0;
    end else if (i_load) begin
      r_quot    <= i_dividend;
      r_rem     <= '0;
      r_divisor <= i_divisor;
      r_cnt     <= '0;
    end else if (i_step && (r_cnt != DIV_STEPS)) begin
      if (!w_diff[WORD_W]) begin
        r_rem  <= w_diff[WORD_W-1:0];
        r_quot <= {r_quot[WORD_W-2:0], 1'b1};
      end else begin
        r_rem  <= w_shift[WORD_W-1:0];
        r_quot <= {r_quot[WORD_W-2:0], 1'b0};
      end
      r_cnt <= r_cnt + 6'd1;
    end
  end

  assign o_quot = r_quot;
  assign o_rem  = r_rem;
  assign o_done = (r_cnt == DIV_STEPS);

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MADD/MSUB and DIV controller driving HI/LO writeback and a pipeline stall.
// Define MULDIV_DIV_EN to build the iterative divider; otherwise DIV/DIVU complete at once with 0.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [2:0]         op_i,
  input  logic [WORD_W-1:0]  opdata1_i,
  input  logic [WORD_W-1:0]  opdata2_i,
  input  logic [DWORD_W-1:0] hilo_i,
  input  logic               annul_i,
  output logic [DWORD_W-1:0] result_o,
  output logic               ready_o,
  output logic               whilo_o,
  output logic               stallreq_o
);

  state_e             r_state;
  logic [DWORD_W-1:0] r_prod;
  logic [DWORD_W-1:0] r_result;
  logic               r_sub;
  logic               r_ready;

  op_e                w_op;
  logic               w_mul_signed;
  logic [DWORD_W-1:0] w_mul_a;
  logic [DWORD_W-1:0] w_mul_b;
  logic [DWORD_W-1:0] w_prod;
  logic [DWORD_W-1:0] w_sum;
  logic               w_op_busy;

  assign w_op         = op_e'(op_i);
  assign w_mul_signed = (w_op == OP_MADD) || (w_op == OP_MSUB);
  assign w_mul_a      = w_mul_signed ? {{WORD_W{opdata1_i[WORD_W-1]}}, opdata1_i}
                                     : {{WORD_W{1'b0}}, opdata1_i};
  assign w_mul_b      = w_mul_signed ? {{WORD_W{opdata2_i[WORD_W-1]}}, opdata2_i}
                                     : {{WORD_W{1'b0}}, opdata2_i};
  // Low 64 bits of the extended product are correct for both signed and unsigned
  assign w_prod       = w_mul_a * w_mul_b;
  assign w_sum        = r_sub ? (hilo_i - r_prod) : (hilo_i + r_prod);

`ifdef MULDIV_DIV_EN
  logic               r_neg_q;
  logic               r_neg_r;
  logic               w_div_signed;
  logic [WORD_W-1:0]  w_abs_a;
  logic [WORD_W-1:0]  w_abs_b;
  logic               w_div_load;
  logic               w_div_step;
  logic               w_div_done;
  logic [WORD_W-1:0]  w_quot;
  logic [WORD_W-1:0]  w_rem;
  logic [WORD_W-1:0]  w_quot_fix;
  logic [WORD_W-1:0]  w_rem_fix;

  assign w_div_signed = (w_op == OP_DIV);
  assign w_abs_a      = (w_div_signed && opdata1_i[WORD_W-1]) ? -opdata1_i : opdata1_i;
  assign w_abs_b      = (w_div_signed && opdata2_i[WORD_W-1]) ? -opdata2_i : opdata2_i;
  assign w_div_load   = rst && !annul_i && (r_state == ST_IDLE) && start_i &&
                        ((w_op == OP_DIV) || (w_op == OP_DIVU)) && (opdata2_i != '0);
  assign w_div_step   = (r_state == ST_DIV_ON) && !w_div_done;
  assign w_quot_fix   = r_neg_q ? -w_quot : w_quot;
  assign w_rem_fix    = r_neg_r ? -w_rem : w_rem;

  div_core u_div_core (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_div_load),
    .i_step     (w_div_step),
    .i_dividend (w_abs_a),
    .i_divisor  (w_abs_b),
    .o_quot     (w_quot),
    .o_rem      (w_rem),
    .o_done     (w_div_done)
  );
`endif

  // Once an op is accepted the latched op decides; op_i is only looked at in IDLE
  assign w_op_busy  = (r_state == ST_IDLE) ? is_muldiv_op(op_i) : 1'b1;
  assign stallreq_o = rst && start_i && !r_ready && w_op_busy;
  assign result_o   = r_result;
  assign ready_o    = r_ready;
  assign whilo_o    = r_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_prod   <= '0;
      r_result <= '0;
      r_sub    <= 1'b0;
      r_ready  <= 1'b0;
`ifdef MULDIV_DIV_EN
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
`endif
    end else if (annul_i) begin
      r_state  <= ST_IDLE;
      r_result <= '0;
      r_ready  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            case (w_op)
              OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                r_prod  <= w_prod;
                r_sub   <= (w_op == OP_MSUB) || (w_op == OP_MSUBU);
                r_state <= ST_MAC;
              end
              OP_DIV, OP_DIVU: begin
`ifdef MULDIV_DIV_EN
                if (opdata2_i == '0) begin
                  r_state <= ST_DIV_ZERO;
                end else begin
                  r_neg_q <= w_div_signed && (opdata1_i[WORD_W-1] ^ opdata2_i[WORD_W-1]);
                  r_neg_r <= w_div_signed && opdata1_i[WORD_W-1];
                  r_state <= ST_DIV_ON;
                end
`else
                r_result <= '0;
                r_ready  <= 1'b1;
                r_state  <= ST_DONE;
`endif
              end
              default: ;
            endcase
          end
        end
        ST_MAC: begin
          r_result <= w_sum;
          r_ready  <= 1'b1;
          r_state  <= ST_DONE;
        end
`ifdef MULDIV_DIV_EN
        ST_DIV_ZERO: begin
          r_result <= '0;
          r_ready  <= 1'b1;
          r_state  <= ST_DONE;
        end
        ST_DIV_ON: begin
          if (w_div_done) begin
            r_result <= {w_rem_fix, w_quot_fix};
            r_ready  <= 1'b1;
            r_state  <= ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          if (!start_i) begin
            r_result <= '0;
            r_ready  <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have one clock, clk. Reset, rst, SHALL be synchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-low reset; 0 sampled on a clk edge resets the block.
REQ-004 start_i  input  1  EX stage holds a multi-cycle op; held high until the pipeline advances.
REQ-005 op_i  input  3  0 NOP, 1 MADD, 2 MADDU, 3 MSUB, 4 MSUBU, 5 DIV, 6 DIVU, 7 reserved (treated as NOP).
REQ-006 opdata1_i  input  32  multiplicand or dividend.
REQ-007 opdata2_i  input  32  multiplier or divisor.
REQ-008 hilo_i  input  64  forwarded {HI,LO}, already resolved for MEM/WB hazards.
REQ-009 annul_i  input  1  flush; abandons the op in flight.
REQ-010 result_o  output  64  {HI,LO} result; DIV/DIVU give {remainder, quotient}.
REQ-011 ready_o  output  1  result_o valid.
REQ-012 whilo_o  output  1  HI/LO write enable; equals ready_o.
REQ-013 stallreq_o  output  1  stall request to the pipeline controller.

Function
REQ-014 FSM states SHALL be IDLE, MAC, DIV_ON, DIV_ZERO and DONE.
REQ-015 IDLE, start_i=1, op MADD/MADDU/MSUB/MSUBU: register the 64-bit product and go to MAC.
REQ-016 MADD and MSUB SHALL form a signed product. MADDU and MSUBU SHALL form an unsigned product.
REQ-017 MAC SHALL sample hilo_i, register hilo_i+prod (MADD*) or hilo_i-prod (MSUB*) modulo 2^64, then go to DONE.
REQ-018 IDLE, start_i=1, op DIV/DIVU, opdata2_i=0: go to DIV_ZERO. DIV_ZERO SHALL register result 0 and go to DONE.
REQ-019 IDLE, start_i=1, op DIV/DIVU, divisor nonzero: latch the operands (absolute values for DIV), clear the iteration counter and go to DIV_ON.
REQ-020 DIV_ON SHALL perform one restoring shift-subtract step per cycle for 32 steps.
REQ-021 The cycle after the 32nd step SHALL apply sign fixup and go to DONE.
REQ-022 Sign fixup (DIV only): quotient negated when the operand signs differ; remainder takes the sign of the dividend.
REQ-023 DONE SHALL hold result_o and drive ready_o=1 while start_i=1. DONE, start_i=0: go to IDLE, ready_o=0.
REQ-024 Latency, start accepted at cycle T: MAC* ready_o at T+2; DIV_ZERO at T+2; DIV/DIVU at T+34.
REQ-025 stallreq_o SHALL be start_i AND NOT ready_o for ops 1-6. It SHALL be 0 for NOP.
REQ-026 annul_i=1 in any non-IDLE state: next state IDLE, ready_o=0 and whilo_o=0 from the next cycle, result discarded.
REQ-027 annul_i together with start_i in IDLE: the op SHALL NOT be accepted.
REQ-028 Operand and op_i changes after acceptance SHALL be ignored until return to IDLE.
REQ-029 result_o SHALL be 0 whenever ready_o=0.

Reset
REQ-030 On reset: state IDLE, counter 0, result_o=0, ready_o=0, whilo_o=0, stallreq_o=0.
REQ-031 Reset mid-operation SHALL abandon the operation without any HI/LO write.

Configuration
REQ-032 Macro MULDIV_DIV_EN SHALL control the divider.
REQ-033 MULDIV_DIV_EN defined: the divider, DIV_ON and DIV_ZERO SHALL be present.
REQ-034 MULDIV_DIV_EN undefined: the divider and its states SHALL be omitted. DIV/DIVU SHALL go IDLE->DONE with result 0 and ready_o at T+1.

Structure
REQ-035 Op encodings, FSM state encodings and the 64-bit/32-bit width constants SHALL reside in the shared defines package.
REQ-036 The shift-subtract step and iteration register SHALL be a sub-module, div_core, instantiated only under MULDIV_DIV_EN.

Verification
REQ-037 MADD 0x00000003 x 0xFFFFFFFE, hilo_i=0x000000000000000A, start at T -> stallreq_o high at T and T+1; ready_o at T+2; result_o=0x0000000000000004.
REQ-038 MSUBU 0xFFFFFFFF x 0x00000002, hilo_i=0x0000000200000000 -> ready_o at T+2; result_o=0x0000000000000002.
REQ-039 DIV 0xFFFFFFF9 / 0x00000002 -> ready_o at T+34; result_o=0xFFFFFFFFFFFFFFFD.
REQ-040 DIVU 5 / 0 -> DIV_ZERO path; ready_o at T+2; result_o=0.
REQ-041 DIV started at T, annul_i pulsed at T+10 -> stallreq_o and ready_o low from T+11; a new MADD at T+12 completes at T+14.
REQ-042 rst=0 at T+5 of a DIV; MULDIV_DIV_EN-off build: DIVU 9/3 -> after reset all outputs 0; off build ready_o at T+1 with result_o=0.
